// File: rtl/fp_div_hs.sv
// Signed fixed-point divider q = trunc((x << FBITS) / y) with valid/ready on both sides.
// Latency: N = (WIDTH+FBITS)/STEPS cycles after accept (1 cycle for a zero divisor).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE. Optional macro: FP_DIV_SAT_EN.
module fp_div_hs #(
  parameter int WIDTH = 32,
  parameter int FBITS = 24,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz,
  output logic             ovf
);

  localparam int ITER = WIDTH + FBITS;
  localparam int N    = ITER / STEPS;
  localparam int CW   = $clog2(N + 1);
  localparam logic [CW-1:0]    LAST = CW'(N - 1);
  localparam logic [WIDTH-1:0] QMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] QMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc;      // partial remainder, always < 2*|y| after a shift
  logic [ITER-1:0]  dq;       // dividend bits shift out the top, quotient bits shift in at the bottom
  logic [WIDTH-1:0] ymag;
  logic             neg;      // quotient sign
  logic             xneg;     // remainder sign
  logic             zdiv;     // divisor was zero: finish after one pass through RUN

  // Magnitudes as unsigned WIDTH-bit values; the most negative input maps to 2^(WIDTH-1)
  logic [WIDTH-1:0] xmag_in;
  logic [WIDTH-1:0] ymag_in;
  assign xmag_in = x[WIDTH-1] ? -x : x;
  assign ymag_in = y[WIDTH-1] ? -y : y;

  // Combinational result of the next STEPS restoring shift-subtract steps
  logic [WIDTH:0]   acc_w;
  logic [ITER-1:0]  dq_w;
  logic [WIDTH:0]   sh;

  // STEPS unrolled restoring division steps
  always_comb begin
    acc_w = acc;
    dq_w  = dq;
    sh    = '0;
    for (int i = 0; i < STEPS; i++) begin
      sh   = {acc_w[WIDTH-1:0], dq_w[ITER-1]};
      dq_w = {dq_w[ITER-2:0], 1'b0};
      if (sh >= {1'b0, ymag}) begin
        acc_w   = sh - {1'b0, ymag};
        dq_w[0] = 1'b1;
      end else begin
        acc_w = sh;
      end
    end
  end

  // Final-result formatting, used only on the last RUN cycle
  logic [WIDTH-1:0] ql;
  logic             hi_nz;    // any quotient bit landed above the result width
  logic             ovf_w;
  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] r_w;

  // Overflow detection and sign restoration of quotient and remainder
  always_comb begin
    ql    = dq_w[WIDTH-1:0];
    hi_nz = |(dq_w >> WIDTH);
    if (neg) begin
      ovf_w = hi_nz || (ql[WIDTH-1] && (|ql[WIDTH-2:0]));
    end else begin
      ovf_w = hi_nz || ql[WIDTH-1];
    end
    q_w = neg  ? -ql : ql;
    r_w = xneg ? -acc_w[WIDTH-1:0] : acc_w[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and handshake outputs decoded from state
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_RUN;
      end
      S_RUN: begin
        if (zdiv || (cnt == LAST)) state_nx = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand capture, iteration and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      acc  <= '0;
      dq   <= '0;
      ymag <= '0;
      neg  <= 1'b0;
      xneg <= 1'b0;
      zdiv <= 1'b0;
      q    <= '0;
      r    <= '0;
      dbz  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            neg  <= x[WIDTH-1] ^ y[WIDTH-1];
            xneg <= x[WIDTH-1];
            zdiv <= (y == '0);
            ymag <= ymag_in;
            acc  <= '0;
            dq   <= ITER'(xmag_in) << FBITS;
            cnt  <= '0;
            q    <= '0;
            r    <= '0;
            dbz  <= 1'b0;
            ovf  <= 1'b0;
          end
        end
        S_RUN: begin
          if (zdiv) begin
            dbz <= 1'b1;
            ovf <= 1'b0;
            r   <= '0;
`ifdef FP_DIV_SAT_EN
            q   <= xneg ? QMIN : QMAX;
`else
            q   <= '0;
`endif
          end else begin
            acc <= acc_w;
            dq  <= dq_w;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              dbz <= 1'b0;
              ovf <= ovf_w;
              if (ovf_w) begin
                r <= '0;
`ifdef FP_DIV_SAT_EN
                q <= neg ? QMIN : QMAX;
`else
                q <= '0;
`endif
              end else begin
                q <= q_w;
                r <= r_w;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_hs.sv
// Bench for fp_div_hs: directed and random operations on STEPS=1 and STEPS=4 instances.
// Latency, results, back-pressure hold and mid-operation reset are checked against a model.
// Model uses plain 64-bit integer division on operand magnitudes.
module tb_fp_div_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        sel;          // 0: STEPS=1 instance, 1: STEPS=4 instance
  logic [31:0] x, y;

  logic        ir1, ov1, dbz1, ovf1;
  logic [31:0] q1, r1;
  logic        ir4, ov4, dbz4, ovf4;
  logic [31:0] q4, r4;

  logic        ir, ov, dbz, ovf;
  logic [31:0] q, r;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_div_hs #(.WIDTH(32), .FBITS(24), .STEPS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(ir1),
    .x(x), .y(y), .out_valid(ov1), .out_ready(out_ready & ~sel),
    .q(q1), .r(r1), .dbz(dbz1), .ovf(ovf1)
  );

  fp_div_hs #(.WIDTH(32), .FBITS(24), .STEPS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(ir4),
    .x(x), .y(y), .out_valid(ov4), .out_ready(out_ready & sel),
    .q(q4), .r(r4), .dbz(dbz4), .ovf(ovf4)
  );

  assign ir  = sel ? ir4  : ir1;
  assign ov  = sel ? ov4  : ov1;
  assign q   = sel ? q4   : q1;
  assign r   = sel ? r4   : r1;
  assign dbz = sel ? dbz4 : dbz1;
  assign ovf = sel ? ovf4 : ovf1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: q = trunc((x << 24) / y) on Q8.24, computed on magnitudes with integer division
  function automatic void model(input logic [31:0] xi, input logic [31:0] yi,
                                output logic [31:0] eq, output logic [31:0] er,
                                output logic edbz, output logic eovf);
    logic [63:0] ax, ay, num, qm, rm;
    logic        ng;
    eq = '0; er = '0; edbz = 1'b0; eovf = 1'b0;
    if (yi == 32'h0) begin
      edbz = 1'b1;
`ifdef FP_DIV_SAT_EN
      eq = xi[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    end else begin
      ax  = xi[31] ? (64'h1_0000_0000 - {32'h0, xi}) : {32'h0, xi};
      ay  = yi[31] ? (64'h1_0000_0000 - {32'h0, yi}) : {32'h0, yi};
      ng  = xi[31] ^ yi[31];
      num = ax << 24;
      qm  = num / ay;
      rm  = num % ay;
      eovf = ng ? (qm > 64'h8000_0000) : (qm > 64'h7FFF_FFFF);
      if (eovf) begin
`ifdef FP_DIV_SAT_EN
        eq = ng ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      end else begin
        eq = ng ? 32'(64'h0 - qm) : qm[31:0];
        er = xi[31] ? 32'(64'h0 - rm) : rm[31:0];
      end
    end
  endfunction

  // One full operation: accept, wait for result, optional back-pressure hold, handshake
  task automatic run_op(input logic [31:0] xi, input logic [31:0] yi, input int hold);
    logic [31:0] eq, er;
    logic        edbz, eovf;
    int          cyc;
    int          elat;
    model(xi, yi, eq, er, edbz, eovf);
    elat = (yi == 32'h0) ? 1 : (sel ? 14 : 56);
    check("in_ready_before_accept", 64'(ir), 64'(1'b1));
    x = xi; y = yi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = $urandom; y = $urandom;
    cyc = 0;
    while (!ov && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(elat));
    check("q", 64'(q), 64'(eq));
    check("r", 64'(r), 64'(er));
    check("dbz", 64'(dbz), 64'(edbz));
    check("ovf", 64'(ovf), 64'(eovf));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; x = $urandom; y = $urandom;
      @(posedge clk); #1;
      check("hold_out_valid", 64'(ov), 64'(1'b1));
      check("hold_in_ready", 64'(ir), 64'(1'b0));
      check("hold_q", 64'(q), 64'(eq));
      check("hold_r", 64'(r), 64'(er));
      check("hold_flags", 64'({dbz, ovf}), 64'({edbz, eovf}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_handshake", 64'(ov), 64'(1'b0));
    check("in_ready_after_handshake", 64'(ir), 64'(1'b1));
  endtask

  initial begin
    logic [31:0] xr, yr;
    int          mode;
    logic        seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state on both instances
    check("rst_in_ready1", 64'(ir1), 64'(1'b1));
    check("rst_out_valid1", 64'(ov1), 64'(1'b0));
    check("rst_q1", 64'(q1), 64'(0));
    check("rst_r1", 64'(r1), 64'(0));
    check("rst_flags1", 64'({dbz1, ovf1}), 64'(0));
    check("rst_in_ready4", 64'(ir4), 64'(1'b1));
    check("rst_out_valid4", 64'(ov4), 64'(1'b0));
    check("rst_q4", 64'(q4), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, STEPS=1
    run_op(32'h0300_0000, 32'h0200_0000, 0);
    run_op(32'h0000_0001, 32'h0000_0003, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0003, 0);
    run_op(32'h8000_0000, 32'h0100_0000, 0);
    run_op(32'h8000_0000, 32'hFF00_0000, 0);
    run_op(32'h0500_0000, 32'h0000_0000, 0);
    run_op(32'hFB00_0000, 32'h0000_0000, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 0);

    // Directed cases, STEPS=4
    sel = 1'b1;
    run_op(32'h0300_0000, 32'h0200_0000, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0003, 0);
    run_op(32'h8000_0000, 32'hFF00_0000, 0);
    run_op(32'h0500_0000, 32'h0000_0000, 0);
    sel = 1'b0;

    // Back-pressure: result held 10 cycles with competing in_valid
    run_op(32'hF400_0000, 32'h0700_0000, 10);
    @(posedge clk); #1;
    check("consumed_once", 64'(ov), 64'(1'b0));

    // Reset in the middle of RUN
    x = 32'h0300_0000; y = 32'h0200_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_in_ready", 64'(ir), 64'(1'b1));
    check("midrun_rst_out_valid", 64'(ov), 64'(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (ov) seen = 1'b1;
    end
    check("no_out_valid_after_reset", 64'(seen), 64'(1'b0));
    run_op(32'h0000_0001, 32'h0000_0003, 0);

    // Randomized operations across both instances
    for (int n = 0; n < 30; n++) begin
      sel  = (n % 3 == 0);
      xr   = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        yr = 32'h0;
      end else if (mode <= 3) begin
        yr = 32'($urandom_range(1, 255));
        if ($urandom_range(0, 1) == 1) yr = -yr;
      end else begin
        yr = $urandom;
        if (yr == 32'h0) yr = 32'h1;
      end
      run_op(xr, yr, $urandom_range(0, 3));
    end
    sel = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
